// File: rtl/sort_pkg.sv
// Shared types and constants for the sorted-packet checker and its ready generator.
package sort_pkg;

  typedef enum logic {
    CHK_IDLE   = 1'b0,
    CHK_IN_PKT = 1'b1
  } chk_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr_ready_gen.sv
// Pseudo-random ready generator: free-running Fibonacci LFSR driving a registered ready.
module lfsr_ready_gen
  import sort_pkg::*;
(
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic en_i,
  output logic ready_o
);

  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lfsr    <= LFSR_SEED;
      ready_o <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb(lfsr)};
      ready_o <= !en_i | lfsr[0];
    end
  end

endmodule

// File: rtl/sorted_pkt_checker.sv
// Avalon-ST sink checking packet order, framing and length; reports per-packet results and counts.
// Handshake: a beat transfers on a posedge where snk_valid_i && snk_ready_o; nothing else is inspected.
module sorted_pkt_checker
  import sort_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int MAX_PKT_LEN = 1024,
  localparam int LEN_W      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              bp_en_i,
  input  logic              clear_i,
  output logic              pkt_done_o,
  output logic [LEN_W-1:0]  pkt_len_o,
  output logic              pkt_ok_o,
  output logic              err_order_o,
  output logic              err_framing_o,
  output logic              err_len_o,
  output logic [31:0]       pkt_cnt_o,
  output logic [31:0]       bad_cnt_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  chk_state_e        state, state_n;
  logic [DWIDTH-1:0] prev, prev_n;
  logic [LEN_W-1:0]  len, len_n, len_inc;
  logic              bad, bad_n, pkt_bad;
  logic              accept;
  logic              close_vld, close_ok, sec_vld, sec_ok;
  logic [LEN_W-1:0]  close_len, sec_len;
  logic              set_order, set_frame, set_len;
  logic              pend_vld, pend_ok;
  logic [LEN_W-1:0]  pend_len;

  lfsr_ready_gen u_ready (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .en_i     (bp_en_i),
    .ready_o  (snk_ready_o)
  );

  assign accept  = snk_valid_i && snk_ready_o;
  assign len_inc = (len == LEN_SAT) ? len : len + LEN_ONE;

  always_comb begin
    state_n   = state;
    prev_n    = prev;
    len_n     = len;
    bad_n     = bad;
    pkt_bad   = bad;
    close_vld = 1'b0;
    close_len = '0;
    close_ok  = 1'b0;
    sec_vld   = 1'b0;
    sec_len   = LEN_ONE;
    sec_ok    = 1'b1;
    set_order = 1'b0;
    set_frame = 1'b0;
    set_len   = 1'b0;
    if (accept) begin
      if (state == CHK_IDLE) begin
        if (snk_startofpacket_i) begin
          len_n  = LEN_ONE;
          prev_n = snk_data_i;
          bad_n  = 1'b0;
          if (snk_endofpacket_i) begin
            close_vld = 1'b1;
            close_len = LEN_ONE;
            close_ok  = 1'b1;
          end else begin
            state_n = CHK_IN_PKT;
          end
        end else begin
          set_frame = 1'b1;
        end
      end else if (snk_startofpacket_i) begin
        // Restart: old packet closes bad, this beat opens a fresh one.
        set_frame = 1'b1;
        close_vld = 1'b1;
        close_len = len;
        close_ok  = 1'b0;
        len_n     = LEN_ONE;
        prev_n    = snk_data_i;
        bad_n     = 1'b0;
        if (snk_endofpacket_i) begin
          sec_vld = 1'b1;
          state_n = CHK_IDLE;
        end
      end else begin
        len_n = len_inc;
        if (len_inc > MAX_LEN) begin
          set_len = 1'b1;
          pkt_bad = 1'b1;
        end
        if (snk_data_i < prev) begin
          set_order = 1'b1;
          pkt_bad   = 1'b1;
        end
        prev_n = snk_data_i;
        bad_n  = pkt_bad;
        if (snk_endofpacket_i) begin
          close_vld = 1'b1;
          close_len = len_inc;
          close_ok  = !pkt_bad;
          state_n   = CHK_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state         <= CHK_IDLE;
      prev          <= '0;
      len           <= '0;
      bad           <= 1'b0;
      pend_vld      <= 1'b0;
      pend_len      <= '0;
      pend_ok       <= 1'b0;
      pkt_done_o    <= 1'b0;
      pkt_len_o     <= '0;
      pkt_ok_o      <= 1'b0;
      err_order_o   <= 1'b0;
      err_framing_o <= 1'b0;
      err_len_o     <= 1'b0;
      pkt_cnt_o     <= '0;
      bad_cnt_o     <= '0;
    end else if (clear_i) begin
      state         <= CHK_IDLE;
      prev          <= '0;
      len           <= '0;
      bad           <= 1'b0;
      pend_vld      <= 1'b0;
      pend_len      <= '0;
      pend_ok       <= 1'b0;
      pkt_done_o    <= 1'b0;
      pkt_len_o     <= '0;
      pkt_ok_o      <= 1'b0;
      err_order_o   <= 1'b0;
      err_framing_o <= 1'b0;
      err_len_o     <= 1'b0;
      pkt_cnt_o     <= '0;
      bad_cnt_o     <= '0;
    end else begin
      state         <= state_n;
      prev          <= prev_n;
      len           <= len_n;
      bad           <= bad_n;
      err_order_o   <= err_order_o | set_order;
      err_framing_o <= err_framing_o | set_frame;
      err_len_o     <= err_len_o | set_len;
      // A queued close always leaves first; at most one new close can arrive behind it.
      if (pend_vld) begin
        pkt_done_o <= 1'b1;
        pkt_len_o  <= pend_len;
        pkt_ok_o   <= pend_ok;
        pkt_cnt_o  <= pkt_cnt_o + 32'd1;
        bad_cnt_o  <= bad_cnt_o + {31'd0, !pend_ok};
        pend_vld   <= close_vld;
        pend_len   <= close_len;
        pend_ok    <= close_ok;
      end else if (close_vld) begin
        pkt_done_o <= 1'b1;
        pkt_len_o  <= close_len;
        pkt_ok_o   <= close_ok;
        pkt_cnt_o  <= pkt_cnt_o + 32'd1;
        bad_cnt_o  <= bad_cnt_o + {31'd0, !close_ok};
        pend_vld   <= sec_vld;
        pend_len   <= sec_len;
        pend_ok    <= sec_ok;
      end else begin
        pkt_done_o <= 1'b0;
        pend_vld   <= 1'b0;
      end
    end
  end

endmodule
